// File: rtl/klein_dec_key_store.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : klein_dec_key_store
// Purpose  : KLEIN-80 decryption key store. Expands an 80-bit master key into
//            NR+1 round keys, one schedule step per clock. It then serves the
//            keys last-first over a valid/ready handshake.
// Option   : KLEIN_KEY_REPLAY_EN adds a 'replay' input and a HOLD state. The
//            buffered keys can then be served again without re-expansion.
// Revision : 1.0 - initial release
// ============================================================================
module klein_dec_key_store #(
  parameter int NR  = 16,
  parameter int KW  = 80,
  parameter int RKW = 64,
  localparam int IW = (NR < 1) ? 1 : $clog2(NR + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [KW-1:0]  master_key,
`ifdef KLEIN_KEY_REPLAY_EN
  input  logic           replay,
`endif
  output logic           busy,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [RKW-1:0] rk_data,
  output logic [IW-1:0]  rk_index,
  output logic           rk_last
);

  localparam int H = KW / 2;

`ifdef KLEIN_KEY_REPLAY_EN
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_SERVE, S_HOLD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_SERVE} state_t;
`endif

  // KLEIN 4-bit S-box (an involution)
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h7; 4'h1: y = 4'h4; 4'h2: y = 4'hA; 4'h3: y = 4'h9;
      4'h4: y = 4'h1; 4'h5: y = 4'hF; 4'h6: y = 4'hB; 4'h7: y = 4'h0;
      4'h8: y = 4'hC; 4'h9: y = 4'h3; 4'hA: y = 4'h2; 4'hB: y = 4'h6;
      4'hC: y = 4'h8; 4'hD: y = 4'hE; 4'hE: y = 4'hD; default: y = 4'h5;
    endcase
    return y;
  endfunction

  // One KLEIN key-schedule step. Each half is rotated left by one byte. The
  // halves are swapped/Feisteled. The round constant is XORed into byte 3 of
  // the left half. Bytes 2 and 3 of the right half go through the S-box.
  function automatic logic [KW-1:0] keysched(input logic [KW-1:0] k,
                                             input logic [7:0]    rc);
    logic [H-1:0] a1, b1, a2, b2;
    a1 = {k[KW-9:H], k[KW-1:KW-8]};
    b1 = {k[H-9:0],  k[H-1:H-8]};
    a2 = b1;
    b2 = a1 ^ b1;
    a2[H-17:H-24] = a2[H-17:H-24] ^ rc;
    b2[H-9:H-12]  = sbox(b2[H-9:H-12]);
    b2[H-13:H-16] = sbox(b2[H-13:H-16]);
    b2[H-17:H-20] = sbox(b2[H-17:H-20]);
    b2[H-21:H-24] = sbox(b2[H-21:H-24]);
    return {a2, b2};
  endfunction

  state_t          state_q, state_d;
  logic [KW-1:0]   kreg_q, kreg_d;
  logic [7:0]      rnd_q, rnd_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            rk_valid_q, rk_valid_d;
  logic [RKW-1:0]  rk_data_q, rk_data_d;
  logic [IW-1:0]   rk_index_q, rk_index_d;
  logic            rk_last_q, rk_last_d;

  logic [RKW-1:0]  rk_buf_q [0:NR];
  logic            buf_we;
  logic [IW-1:0]   buf_waddr;
  logic [RKW-1:0]  buf_wdata;

  logic [KW-1:0]   ks_next;
  logic            load_start;

  assign ks_next = keysched(kreg_q, rnd_q);

  // Next-state, buffer write and output-register next values
  always_comb begin
    state_d    = state_q;
    kreg_d     = kreg_q;
    rnd_d      = rnd_q;
    idx_d      = idx_q;
    rk_valid_d = rk_valid_q;
    rk_data_d  = rk_data_q;
    rk_index_d = rk_index_q;
    rk_last_d  = rk_last_q;
    buf_we     = 1'b0;
    buf_waddr  = rnd_q[IW-1:0];
    buf_wdata  = ks_next[KW-1:KW-RKW];
    load_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        load_start = start;
      end
      S_EXPAND: begin
        buf_we = 1'b1;
        kreg_d = ks_next;
        if (rnd_q == 8'(NR)) begin
          state_d = S_SERVE;
          idx_d   = IW'(NR);
        end else begin
          rnd_d = rnd_q + 8'd1;
        end
      end
      S_SERVE: begin
        if (!rk_valid_q) begin
          // First SERVE cycle: load the output registers with the top key
          rk_valid_d = 1'b1;
          rk_data_d  = rk_buf_q[idx_q];
          rk_index_d = idx_q;
          rk_last_d  = (idx_q == '0);
        end else if (rk_ready) begin
          if (idx_q == '0) begin
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
            rnd_d      = 8'd0;
`ifdef KLEIN_KEY_REPLAY_EN
            state_d    = S_HOLD;
`else
            state_d    = S_IDLE;
`endif
          end else begin
            idx_d      = idx_q - IW'(1);
            rk_data_d  = rk_buf_q[idx_q - IW'(1)];
            rk_index_d = idx_q - IW'(1);
            rk_last_d  = (idx_q == IW'(1));
          end
        end
      end
`ifdef KLEIN_KEY_REPLAY_EN
      S_HOLD: begin
        if (start) begin
          load_start = 1'b1;
        end else if (replay) begin
          // The buffer is intact: present the top key on the very next cycle
          state_d    = S_SERVE;
          idx_d      = IW'(NR);
          rk_valid_d = 1'b1;
          rk_data_d  = rk_buf_q[NR];
          rk_index_d = IW'(NR);
          rk_last_d  = (NR == 0);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_start) begin
      kreg_d    = master_key;
      buf_we    = 1'b1;
      buf_waddr = '0;
      buf_wdata = master_key[KW-1:KW-RKW];
      rnd_d     = 8'd1;
      state_d   = S_EXPAND;
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      kreg_q     <= '0;
      rnd_q      <= 8'd0;
      idx_q      <= '0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_index_q <= '0;
      rk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      kreg_q     <= kreg_d;
      rnd_q      <= rnd_d;
      idx_q      <= idx_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_index_q <= rk_index_d;
      rk_last_q  <= rk_last_d;
    end
  end

  // Round-key buffer; contents are only exposed once fully written
  always_ff @(posedge clk) begin
    if (buf_we) begin
      rk_buf_q[buf_waddr] <= buf_wdata;
    end
  end

  assign busy     = (state_q == S_EXPAND) || (state_q == S_SERVE);
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_index = rk_index_q;
  assign rk_last  = rk_last_q;

endmodule
`default_nettype wire

// File: tb/tb_klein_dec_key_store.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_klein_dec_key_store
// Purpose  : Directed self-checking bench for klein_dec_key_store.
// Revision : 1.0 - initial release
// ============================================================================
module tb_klein_dec_key_store;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [79:0] master_key;
`ifdef KLEIN_KEY_REPLAY_EN
  logic        replay;
`endif
  logic        busy;
  logic        rk_valid;
  logic        rk_ready;
  logic [63:0] rk_data;
  logic [4:0]  rk_index;
  logic        rk_last;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_rk [0:16];
  logic [63:0] got    [0:16];

  klein_dec_key_store dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .master_key (master_key),
`ifdef KLEIN_KEY_REPLAY_EN
    .replay     (replay),
`endif
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_data    (rk_data),
    .rk_index   (rk_index),
    .rk_last    (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference S-box lookup from a packed nibble table
  function automatic logic [3:0] gold_sb(input logic [3:0] n);
    logic [63:0] tbl;
    tbl = 64'h74A91FB0C3268ED5;
    return tbl[63 - 4*int'(n) -: 4];
  endfunction

  // Byte-oriented reference of one KLEIN-80 key-schedule step
  function automatic logic [79:0] gold_step(input logic [79:0] k, input int rc);
    logic [7:0]  s [10];
    logic [7:0]  t [10];
    logic [79:0] r;
    logic [7:0]  a, b;
    for (int i = 0; i < 10; i++) s[i] = k[79 - 8*i -: 8];
    for (int j = 0; j < 5; j++) begin
      a = s[(j + 1) % 5];
      b = s[5 + (j + 1) % 5];
      t[j]     = b;
      t[5 + j] = a ^ b;
    end
    t[2] = t[2] ^ rc[7:0];
    t[6] = {gold_sb(t[6][7:4]), gold_sb(t[6][3:0])};
    t[7] = {gold_sb(t[7][7:4]), gold_sb(t[7][3:0])};
    for (int i = 0; i < 10; i++) r[79 - 8*i -: 8] = t[i];
    return r;
  endfunction

  task automatic gen_expected(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    exp_rk[0] = k[79:16];
    for (int r = 1; r <= 16; r++) begin
      k = gold_step(k, r);
      exp_rk[r] = k[79:16];
    end
  endtask

  task automatic do_start(input logic [79:0] key);
    start      = 1'b1;
    master_key = key;
    tick();
    start      = 1'b0;
    master_key = {$urandom, $urandom, 16'hBEEF};
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("valid_after_start", {63'd0, rk_valid}, 64'd0);
  endtask

  // Waits for the first rk_valid; optionally fires a stray start on one cycle
  task automatic wait_valid(input int exp_lat, input int inject_at, input logic [79:0] junk);
    int lat;
    lat = 0;
    while (!rk_valid && lat < 40) begin
      if (lat == inject_at) begin
        start      = 1'b1;
        master_key = junk;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("first_valid_latency", 64'(lat), 64'(exp_lat));
  endtask

  // Drains all 17 keys, checking order, data, rk_last and stall stability
  task automatic collect(input bit use_bp, input int inject_at, input logic [79:0] junk);
    int          xfers, cyc, ei;
    bit          stalled, injected;
    logic [63:0] pd;
    logic [4:0]  pi;
    logic [15:0] pat;
    xfers = 0; cyc = 0; stalled = 0; injected = 0;
    pd = '0; pi = '0;
    pat = 16'b1001_0011_1010_0101;
    while (xfers < 17 && cyc < 300) begin
      rk_ready = use_bp ? pat[15] : 1'b1;
      pat = {pat[14:0], pat[15]};
      if (xfers == inject_at && !injected) begin
        start      = 1'b1;
        master_key = junk;
        injected   = 1;
      end else begin
        start = 1'b0;
      end
      check("valid_held", {63'd0, rk_valid}, 64'd1);
      if (stalled) begin
        check("stall_data", rk_data, pd);
        check("stall_index", {59'd0, rk_index}, {59'd0, pi});
      end
      if (rk_valid && rk_ready) begin
        ei = 16 - xfers;
        check("rk_index", {59'd0, rk_index}, 64'(ei));
        check("rk_data", rk_data, exp_rk[ei]);
        check("rk_last", {63'd0, rk_last}, (ei == 0) ? 64'd1 : 64'd0);
        got[rk_index] = rk_data;
        xfers++;
        stalled = 0;
      end else begin
        stalled = rk_valid;
        pd = rk_data;
        pi = rk_index;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("transfer_count", 64'(xfers), 64'd17);
    if (!use_bp) check("consecutive_cycles", 64'(cyc), 64'd17);
    check("valid_after_last", {63'd0, rk_valid}, 64'd0);
    check("busy_after_last", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    master_key = '0;
    rk_ready   = 1'b1;
`ifdef KLEIN_KEY_REPLAY_EN
    replay     = 1'b0;
`endif
    tick();
    tick();
    check("rst_busy",   {63'd0, busy},     64'd0);
    check("rst_valid",  {63'd0, rk_valid}, 64'd0);
    check("rst_last",   {63'd0, rk_last},  64'd0);
    check("rst_data",   rk_data,           64'd0);
    check("rst_index",  {59'd0, rk_index}, 64'd0);
    rst_n = 1'b1;
    tick();

    // All-zero master key, no backpressure
    gen_expected(80'h0);
    do_start(80'h0);
    wait_valid(17, -1, '0);
    collect(0, -1, '0);
    check("zero_key_rk0", got[0], 64'h0);
    check("zero_key_rk1", got[1], 64'h0000_0100_0000_7777);
    tick();

    // All-ones master key
    gen_expected(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    do_start(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    wait_valid(17, -1, '0);
    collect(0, -1, '0);
    check("ones_key_rk0", got[0], 64'hFFFF_FFFF_FFFF_FFFF);

    // Backpressure on rk_ready
    gen_expected(80'h0123_4567_89AB_CDEF_FEDC);
    do_start(80'h0123_4567_89AB_CDEF_FEDC);
    wait_valid(17, -1, '0);
    collect(1, -1, '0);

    // Stray starts during EXPAND cycle 5 and during SERVE are ignored
    gen_expected(80'h5A5A_C3C3_0F0F_9669_A55A);
    do_start(80'h5A5A_C3C3_0F0F_9669_A55A);
    wait_valid(17, 4, 80'h1111_2222_3333_4444_5555);
    collect(0, 5, 80'h6666_7777_8888_9999_AAAA);

    // Asynchronous reset while serving index 9
    gen_expected(80'h8000_0000_0000_0000_0001);
    do_start(80'h8000_0000_0000_0000_0001);
    wait_valid(17, -1, '0);
    rk_ready = 1'b1;
    n = 0;
    while (rk_index != 5'd9 && n < 40) begin
      tick();
      n++;
    end
    check("reached_idx9", {59'd0, rk_index}, 64'd9);
    rst_n = 1'b0;
    #2;
    check("abort_valid", {63'd0, rk_valid}, 64'd0);
    check("abort_busy",  {63'd0, busy},     64'd0);
    check("abort_index", {59'd0, rk_index}, 64'd0);
    check("abort_data",  rk_data,           64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    gen_expected(80'hDEAD_BEEF_0BAD_F00D_1234);
    do_start(80'hDEAD_BEEF_0BAD_F00D_1234);
    wait_valid(17, -1, '0);
    collect(0, -1, '0);

`ifdef KLEIN_KEY_REPLAY_EN
    // Replay the retained buffer without re-expansion
    tick();
    replay = 1'b1;
    tick();
    replay = 1'b0;
    check("replay_valid", {63'd0, rk_valid}, 64'd1);
    check("replay_index", {59'd0, rk_index}, 64'd16);
    collect(0, -1, '0);

    // Replay while busy is ignored
    gen_expected(80'h0F1E_2D3C_4B5A_6978_8796);
    do_start(80'h0F1E_2D3C_4B5A_6978_8796);
    replay = 1'b1;
    tick();
    replay = 1'b0;
    wait_valid(16, -1, '0);
    collect(0, -1, '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/klein_dec_key_store.md
Name: klein_dec_key_store

Overview:
- Decryption-side key-schedule controller for KLEIN-80.
- Iterates the existing combinational key schedule stage once per clock to expand an 80-bit master key into NR+1 round keys, and buffers them in an internal array.
- Serves the round keys in reverse order (last round key first) to the round datapath through a valid/ready handshake.
- Sits between the key input interface (upstream) and the decryption round datapath (downstream).

Parameters:
- NR, 16, number of cipher rounds; NR+1 round keys are stored.
- KW, 80, master/schedule key width.
- RKW, 64, round-key width; round key = schedule state bits [KW-1:KW-RKW].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to expand master_key; honoured only in IDLE
- master_key  input  80  master key, sampled on the start cycle
- busy  output  1  high in EXPAND and SERVE
- rk_valid  output  1  rk_data/rk_index valid
- rk_ready  input  1  downstream accepts the current round key
- rk_data  output  64  current round key
- rk_index  output  5  index of rk_data (NR down to 0)
- rk_last  output  1  high with rk_valid when rk_index==0

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; busy, rk_valid and rk_last = 0; rk_data and rk_index = 0.
  - Internal round counter = 0; buffer contents don't-care.
- States: IDLE, EXPAND, SERVE.
- IDLE:
  - start=1 latches master_key into the schedule register kreg.
  - Writes buf[0] <= master_key[79:16] and sets rnd <= 1.
  - Next state EXPAND.
- EXPAND: runs one schedule step per cycle.
  - The step computes next = keysched(kreg, rnd), where rnd is zero-extended to 8 bits as the round constant.
  - Writes buf[rnd] <= next[79:16], then kreg <= next.
  - When rnd==NR, moves to SERVE with idx=NR; otherwise rnd++.
  - EXPAND lasts exactly NR cycles.
- SERVE:
  - rk_valid=1, rk_data=buf[idx], rk_index=idx, rk_last=(idx==0).
  - Transfer occurs when rk_valid && rk_ready.
  - On a transfer with idx>0: idx--.
  - On a transfer with idx==0: next state IDLE and rk_valid drops the following cycle.
  - rk_data/rk_index are registered and stay stable while rk_valid=1 && rk_ready=0.
- Latency: first rk_valid is asserted NR+1 cycles after the start edge (cycle 17 at default NR).
- Throughput: with rk_ready tied high, all NR+1 keys are delivered on consecutive cycles.
- busy is high from the cycle after start until the final transfer completes; it is low in IDLE.
- start while busy=1 is ignored: no relatch and no state change.
- master_key changes outside the start cycle have no effect.
- rk_ready while rk_valid=0 is ignored.
- rst_n asserted mid-EXPAND or mid-SERVE aborts immediately to the reset values. Partially written buffer contents are never presented as valid.
- Width rules:
  - Round constant is 8 bits; rnd never exceeds NR ≤ 255.
  - rk_index width is ceil(log2(NR+1)); it is 5 at default.
- Buffer is plain registers (NR+1 x RKW); no RAM macro.

Optional Feature:
- Macro KLEIN_KEY_REPLAY_EN.
- When defined:
  - Adds input port replay (1 bit).
  - After the final transfer, the block enters state HOLD instead of IDLE; busy=0 and the buffer is retained.
  - In HOLD, replay=1 enters SERVE with idx=NR without re-expansion, so the first rk_valid appears the next cycle.
  - In HOLD, start=1 behaves as in IDLE. If replay and start are asserted together, start wins.
- When undefined: no replay port, no HOLD state, and the block returns to IDLE after the final transfer.

Test Plan:
- Basic expansion:
  - Stimulus: master_key=80'h0, start pulse, rk_ready=1.
  - Required: busy rises next cycle; rk_valid rises exactly 17 cycles after start.
  - Required: 17 consecutive transfers with rk_index 16,15,...,0; rk_last only on index 0.
  - Required: rk_data matches the golden model of the schedule iterated with round constants 1..16 in reverse; entry 0 = 64'h0.
- Key with all ones:
  - Stimulus: master_key=80'hFFFF_FFFF_FFFF_FFFF_FFFF.
  - Required: index-0 key = 64'hFFFF_FFFF_FFFF_FFFF; index-16 key matches the golden model.
- Backpressure:
  - Stimulus: rk_ready toggles 1,0,0,1 pseudo-randomly.
  - Required: rk_data/rk_index stay constant while stalled; no key is skipped or duplicated; exactly 17 transfers occur.
- Start while busy:
  - Stimulus: a second start with a different key during EXPAND cycle 5 and during SERVE.
  - Required: ignored; output keys all derive from the first key.
- Reset mid-operation:
  - Stimulus: rst_n low during SERVE at idx=9.
  - Required: rk_valid=0 and busy=0 immediately (asynchronous).
  - Required: a subsequent start produces a full, correct 17-key sequence.
- Replay (with KLEIN_KEY_REPLAY_EN):
  - Stimulus: complete one sequence, then pulse replay.
  - Required: rk_valid rises the next cycle with index 16 and the identical 17-key sequence; replay is ignored while busy.
